// File: rtl/less_compare_checker.sv
// Streaming self-check for the less_test / less_test_hardcaml comparator pair.
// Two-stage pipeline: stage 1 registers the golden borrow subtraction, stage 2 scores it.
module less_compare_checker #(
  parameter int WIDTH       = 8,
  parameter int NUM_SAMPLES = 10,
  parameter int CNT_W       = 16
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c,
  input  logic             ch,
  output logic [WIDTH:0]   diff,
  output logic             expected,
  output logic [CNT_W-1:0] pass_count,
  output logic [CNT_W-1:0] fail_count,
  output logic             first_fail_valid,
  output logic [WIDTH-1:0] first_a,
  output logic [WIDTH-1:0] first_b,
  output logic             first_c,
  output logic             first_ch,
  output logic             busy,
  output logic             done,
  output logic             pass
);

  localparam int SW = $clog2(NUM_SAMPLES + 1);
  localparam logic [SW-1:0] NS = SW'(NUM_SAMPLES);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c;
    logic             ch;
  } smp_t;

  state_t        state;
  logic [SW-1:0] acc_cnt;
  logic [SW-1:0] res_cnt;
  smp_t          s1;
  logic          s1_vld;
  logic          accept;
  logic          mismatch;
  logic [WIDTH:0] sub;

  assign busy     = (state == RUN);
  assign done     = (state == DONE);
  assign in_ready = busy && (acc_cnt < NS);
  assign accept   = in_valid && in_ready;
  assign pass     = done && (fail_count == '0);
  // Zero-extended subtraction: the top bit is the borrow, i.e. a < b.
  assign sub      = {1'b0, a} - {1'b0, b};
  assign mismatch = (s1.c != expected) || (s1.ch != expected);

  always_ff @(posedge clock) begin
    if (clear) begin
      state            <= IDLE;
      acc_cnt          <= '0;
      res_cnt          <= '0;
      s1               <= '0;
      s1_vld           <= 1'b0;
      diff             <= '0;
      expected         <= 1'b0;
      pass_count       <= '0;
      fail_count       <= '0;
      first_fail_valid <= 1'b0;
      first_a          <= '0;
      first_b          <= '0;
      first_c          <= 1'b0;
      first_ch         <= 1'b0;
    end else begin
      s1_vld <= accept;
      if (accept) begin
        s1       <= '{a: a, b: b, c: c, ch: ch};
        diff     <= sub;
        expected <= sub[WIDTH];
        acc_cnt  <= acc_cnt + SW'(1);
      end

      if (s1_vld) begin
        if (mismatch) begin
          if (fail_count != {CNT_W{1'b1}})
            fail_count <= fail_count + CNT_W'(1);
          if (!first_fail_valid) begin
            first_fail_valid <= 1'b1;
            first_a          <= s1.a;
            first_b          <= s1.b;
            first_c          <= s1.c;
            first_ch         <= s1.ch;
          end
        end else begin
          pass_count <= pass_count + CNT_W'(1);
        end
        res_cnt <= res_cnt + SW'(1);
        if (res_cnt == NS - SW'(1))
          state <= DONE;
      end

      // No sample is in flight outside RUN, so a (re)start never races the pipeline.
      if (start && (state != RUN)) begin
        state            <= RUN;
        acc_cnt          <= '0;
        res_cnt          <= '0;
        pass_count       <= '0;
        fail_count       <= '0;
        first_fail_valid <= 1'b0;
        first_a          <= '0;
        first_b          <= '0;
        first_c          <= 1'b0;
        first_ch         <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_less_compare_checker.sv
// Scoreboard bench for less_compare_checker: driver queues expected diff/expected per
// accepted sample, a monitor pops on every accept edge; run-level results checked directly.
module tb_less_compare_checker;

  logic       clock = 1'b0;
  logic       clear = 1'b1;
  logic       start = 1'b0;
  logic       start2 = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       c = 1'b0;
  logic       ch = 1'b0;

  logic        in_ready, expected, first_fail_valid, first_c, first_ch, busy, done, pass;
  logic [8:0]  diff;
  logic [15:0] pass_count, fail_count;
  logic [7:0]  first_a, first_b;

  logic       in_ready2, expected2, first_fail_valid2, first_c2, first_ch2, busy2, done2, pass2;
  logic [8:0] diff2;
  logic [1:0] pass_count2, fail_count2;
  logic [7:0] first_a2, first_b2;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [8:0] d;
    logic       e;
  } exp_t;
  exp_t q[$];

  logic [7:0] va[10] = '{8'h03, 8'h05, 8'h7F, 8'h00, 8'hFF, 8'h80, 8'h7F, 8'h01, 8'h00, 8'hAA};
  logic [7:0] vb[10] = '{8'h05, 8'h03, 8'h7F, 8'hFF, 8'h00, 8'h7F, 8'h80, 8'h00, 8'h01, 8'h55};
  logic [8:0] vd[10] = '{9'h1FE, 9'h002, 9'h000, 9'h101, 9'h0FF, 9'h001, 9'h1FF, 9'h001, 9'h1FF, 9'h055};

  always #5 clock = ~clock;

  less_compare_checker #(.WIDTH(8), .NUM_SAMPLES(10), .CNT_W(16)) dut (
    .clock(clock), .clear(clear), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c(c), .ch(ch), .diff(diff), .expected(expected),
    .pass_count(pass_count), .fail_count(fail_count), .first_fail_valid(first_fail_valid),
    .first_a(first_a), .first_b(first_b), .first_c(first_c), .first_ch(first_ch),
    .busy(busy), .done(done), .pass(pass)
  );

  less_compare_checker #(.WIDTH(8), .NUM_SAMPLES(5), .CNT_W(2)) dut2 (
    .clock(clock), .clear(clear), .start(start2), .in_valid(in_valid), .in_ready(in_ready2),
    .a(a), .b(b), .c(c), .ch(ch), .diff(diff2), .expected(expected2),
    .pass_count(pass_count2), .fail_count(fail_count2), .first_fail_valid(first_fail_valid2),
    .first_a(first_a2), .first_b(first_b2), .first_c(first_c2), .first_ch(first_ch2),
    .busy(busy2), .done(done2), .pass(pass2)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Drive one sample for one cycle (inputs change on the falling edge).
  task automatic send(input logic [7:0] xa, input logic [7:0] xb, input logic xc,
                      input logic xch, input logic [8:0] xd, input bit push);
    exp_t e;
    a = xa; b = xb; c = xc; ch = xch; in_valid = 1'b1;
    if (push) begin
      e.d = xd;
      e.e = xd[8];
      q.push_back(e);
    end
    @(negedge clock);
  endtask

  always @(posedge clock) begin : mon
    bit   acc;
    exp_t e;
    acc = (in_valid === 1'b1) && (in_ready === 1'b1) && !clear;
    @(negedge clock);
    if (acc) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_accept actual=diff %0h expected=no accept", diff);
      end else begin
        e = q.pop_front();
        chk("sb_diff", 32'(diff), 32'(e.d));
        chk("sb_expected", 32'(expected), 32'(e.e));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clock);
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_pass", 32'(pass), 0);
    chk("rst_counts", {pass_count, fail_count}, 0);
    chk("rst_diff", {diff, expected}, 0);
    chk("rst_first", {first_fail_valid, first_a, first_b, first_c, first_ch}, 0);
    clear = 1'b0;

    // in_valid while IDLE is ignored
    send(8'h12, 8'h34, 1'b1, 1'b1, 9'h1DE, 1'b0);
    in_valid = 1'b0;
    chk("idle_ignore_diff", 32'(diff), 0);
    chk("idle_ignore_busy", 32'(busy), 0);

    // Run 1: ten correct samples back-to-back, then an eleventh that must be refused
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    chk("run1_busy", 32'(busy), 1);
    chk("run1_in_ready", 32'(in_ready), 1);
    for (int i = 0; i < 10; i++) send(va[i], vb[i], vd[i][8], vd[i][8], vd[i], 1'b1);
    chk("run1_ready_drop", 32'(in_ready), 0);
    chk("run1_done_early", 32'(done), 0);
    send(8'h12, 8'h34, 1'b0, 1'b0, 9'h1DE, 1'b0);
    in_valid = 1'b0;
    chk("run1_done", 32'(done), 1);
    chk("run1_pass_count", 32'(pass_count), 10);
    chk("run1_fail_count", 32'(fail_count), 0);
    chk("run1_pass", 32'(pass), 1);
    chk("run1_diff_hold", 32'(diff), 32'h055);
    chk("run1_no_first", 32'(first_fail_valid), 0);

    // Run 2: restart from DONE with start held, two injected mismatches
    start = 1'b1;
    @(negedge clock);
    chk("run2_busy", 32'(busy), 1);
    chk("run2_done_low", 32'(done), 0);
    chk("run2_zeroed", {pass_count, fail_count}, 0);
    send(8'h10, 8'h20, 1'b1, 1'b0, 9'h1F0, 1'b1);
    send(8'h01, 8'h02, 1'b0, 1'b1, 9'h1FF, 1'b1);
    for (int i = 0; i < 8; i++) begin
      send(va[i], vb[i], vd[i][8], vd[i][8], vd[i], 1'b1);
      if (i == 0) start = 1'b0;
    end
    in_valid = 1'b0;
    @(negedge clock);
    chk("run2_done", 32'(done), 1);
    chk("run2_pass_count", 32'(pass_count), 8);
    chk("run2_fail_count", 32'(fail_count), 2);
    chk("run2_pass", 32'(pass), 0);
    chk("run2_first_valid", 32'(first_fail_valid), 1);
    chk("run2_first_ab", {first_a, first_b}, 32'h1020);
    chk("run2_first_c_ch", {first_c, first_ch}, 32'b10);

    // Run 3: clear after four accepts, then a fresh run counts from zero
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    for (int i = 0; i < 4; i++) send(va[i], vb[i], vd[i][8], vd[i][8], vd[i], 1'b1);
    clear = 1'b1;
    in_valid = 1'b0;
    @(negedge clock);
    clear = 1'b0;
    chk("clr_state", {busy, done, in_ready, pass}, 0);
    chk("clr_counts", {pass_count, fail_count}, 0);
    chk("clr_diff", {diff, expected}, 0);
    chk("clr_first", {first_fail_valid, first_a, first_b, first_c, first_ch}, 0);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    send(va[3], vb[3], vd[3][8], vd[3][8], vd[3], 1'b1);
    send(va[4], vb[4], vd[4][8], vd[4][8], vd[4], 1'b1);
    in_valid = 1'b0;
    @(negedge clock);
    chk("rerun_pass_count", 32'(pass_count), 2);
    chk("rerun_busy", 32'(busy), 1);
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;

    // Saturation: five mismatches into a 2-bit fail counter
    start2 = 1'b1;
    @(negedge clock);
    start2 = 1'b0;
    for (int i = 0; i < 5; i++) send(va[i], vb[i], ~vd[i][8], ~vd[i][8], vd[i], 1'b0);
    in_valid = 1'b0;
    chk("sat_done_early", 32'(done2), 0);
    @(negedge clock);
    chk("sat_done", 32'(done2), 1);
    chk("sat_fail_count", 32'(fail_count2), 3);
    chk("sat_pass_count", 32'(pass_count2), 0);
    chk("sat_pass", 32'(pass2), 0);
    chk("sat_first_a", 32'(first_a2), 32'h03);
    chk("main_idle_ignore", {busy, pass_count}, 0);
    chk("sb_drained", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
